// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic                isDiv;
  logic                negRes;
  logic                negRem;
  logic                divZero;
  logic [DATA_W-1:0]   aReg;
  logic [DATA_W-1:0]   bReg;
  logic [DATA_W-1:0]   rawA;
  logic [2*DATA_W-1:0] acc;

  logic                isSigned;
  logic [DATA_W-1:0]   absA;
  logic [DATA_W-1:0]   absB;
  logic [DATA_W:0]     mulSum;
  logic [DATA_W:0]     remShift;
  logic [DATA_W:0]     divTrial;
  logic                qBit;
  logic [2*DATA_W-1:0] prodFix;
  logic [DATA_W-1:0]   quotFix;
  logic [DATA_W-1:0]   remFix;

  always_comb begin
    isSigned = ~op[0];
    absA     = (isSigned && opA[DATA_W-1]) ? -opA : opA;
    absB     = (isSigned && opB[DATA_W-1]) ? -opB : opB;
  end

  // Multiply: aReg is the multiplicand, bReg shifts out multiplier bits LSB first,
  // product bits shift down into the low half of acc.
  always_comb begin
    mulSum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (bReg[0] ? {1'b0, aReg} : '0);
  end

  // Divide: acc high half is the partial remainder, low half collects quotient bits;
  // aReg shifts out dividend bits MSB first. Trial borrow means "restore".
  always_comb begin
    remShift = {acc[2*DATA_W-1:DATA_W], aReg[DATA_W-1]};
    divTrial = remShift - {1'b0, bReg};
    qBit     = ~divTrial[DATA_W];
  end

  always_comb begin
    prodFix = negRes ? -acc : acc;
    quotFix = negRes ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    remFix  = negRem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fastProd;
  always_comb begin
    fastProd = {{DATA_W{1'b0}}, absA} * {{DATA_W{1'b0}}, absB};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      aReg    <= '0;
      bReg    <= '0;
      rawA    <= '0;
      acc     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start) begin
            isDiv   <= op[1];
            negRes  <= isSigned & (opA[DATA_W-1] ^ opB[DATA_W-1]);
            negRem  <= isSigned & op[1] & opA[DATA_W-1];
            divZero <= (opB == '0);
            aReg    <= absA;
            bReg    <= absB;
            rawA    <= opA;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef MULDIV_FAST_MUL_EN
            if (!op[1]) begin
              acc   <= fastProd;
              state <= FIX;
            end
`endif
          end
        end
        RUN: begin
          if (isDiv) begin
            acc  <= {(qBit ? divTrial[DATA_W-1:0] : remShift[DATA_W-1:0]),
                     acc[DATA_W-2:0], qBit};
            aReg <= aReg << 1;
          end else begin
            acc  <= {mulSum, acc[DATA_W-1:1]};
            bReg <= bReg >> 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= FIX;
        end
        FIX: begin
          if (isDiv) begin
            if (divZero) begin
              hi <= rawA;
              lo <= '1;
            end else begin
              hi <= remFix;
              lo <= quotFix;
            end
          end else begin
            hi <= prodFix[2*DATA_W-1:DATA_W];
            lo <= prodFix[DATA_W-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random vs. arithmetic model.
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] opA, opB, wr_data;
  logic         wr_hi, wr_lo;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int nVec = 0;
  int nMis = 0;
  logic [W-1:0] lastHoldLo;

  muldiv_unit #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [31:0] a, b, expHi, expLo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Called just after a clock edge (#1); launches one op and tracks it to done.
  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int injectAt);
    int k;
    bit got, holdOk, busyOk;
    logic [31:0] holdHi, holdLo;
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'($urandom); opA = $urandom; opB = $urandom;
    holdHi = hi; holdLo = lo; lastHoldLo = lo;
    k = 0; got = 0; holdOk = 1; busyOk = 1;
    while (k < 100 && !got) begin
      if (!busy) busyOk = 0;
      @(posedge clk); #1;
      k++;
      if (k == injectAt) begin
        start = 1'b1; op = 2'b01; opA = 32'd5; opB = 32'd5;
        wr_hi = 1'b1; wr_data = 32'hAAAA;
      end else if (k == injectAt + 1) begin
        start = 1'b0; wr_hi = 1'b0;
      end
      if (done) got = 1;
      else if (hi !== holdHi || lo !== holdLo) holdOk = 0;
    end
    check({name, " latency"}, 64'(k), 64'(o[1] ? DIV_LAT : MUL_LAT));
    check({name, " busy during op"}, 64'(busyOk), 64'd1);
    check({name, " hi/lo hold"}, 64'(holdOk), 64'd1);
    check({name, " busy at done"}, 64'(busy), 64'd0);
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    @(posedge clk); #1;
    check({name, " done pulse width"}, 64'(done), 64'd0);
    start = 1'b0; wr_hi = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    logic [63:0] m;
    bit sawDone;

    vecs.push_back('{"multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{"mult_zero", 2'b00, 32'd0, 32'h8000_0000, 32'd0, 32'd0});
    vecs.push_back('{"div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"div_7byneg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_100by7", 2'b11, 32'd100, 32'd7, 32'd2, 32'h0000_000E});
    vecs.push_back('{"div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000});
    vecs.push_back('{"divu_by0", 2'b11, 32'h1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF});
    vecs.push_back('{"div_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF});

    reset = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, -1);

    // start + MTHI + new operands mid-divide must all be ignored
    runOp("divu_ignore_mid", 2'b11, 32'd100, 32'd7, 32'd2, 32'h0000_000E, 10);

    // MTLO in idle
    wr_lo = 1'b1; wr_data = 32'h5555;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    check("mtlo lo", 64'(lo), 64'h5555);
    check("mtlo hi kept", 64'(hi), 64'd2);
    check("mtlo done", 64'(done), 64'd0);

    // MTLO together with start: write visible first, then overwritten by result
    wr_lo = 1'b1; wr_data = 32'h7777;
    runOp("start_with_mtlo", 2'b11, 32'd50, 32'd6, 32'd2, 32'd8, -1);
    check("start_with_mtlo write", 64'(lastHoldLo), 64'h7777);

    // MTHI + MTLO together
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h1111;
    @(posedge clk); #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthi_mtlo hi", 64'(hi), 64'h1111);
    check("mthi_mtlo lo", 64'(lo), 64'h1111);

    // Abort by reset at cycle 20 of an in-flight op
    start = 1'b1; opA = 32'h0001_2345; opB = 32'h0000_6789;
`ifdef MULDIV_FAST_MUL_EN
    op = 2'b10;
`else
    op = 2'b00;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    sawDone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || hi !== 32'd0 || lo !== 32'd0) sawDone = 1;
    end
    check("abort no late result", 64'(sawDone), 64'd0);
    runOp("after_abort", 2'b01, 32'd12345, 32'd678, 32'd0, 32'd8369910, -1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 7) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      m = model(ro, ra, rb);
      runOp($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, m[63:32], m[31:0], -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
